alu_sweep_checker: RTL
======================

# alu_sweep_checker

Self-checking stimulus engine for the 4-bit switch-driven ALU top. It sits on the opposite side of that ALU's board interface. It drives the 16-bit switch word (`{5'b0, func[2:0], b[3:0], a[3:0]}`) and reads back the 16-bit LED word (`{6'b0, f[3:0], overflow, cout, sum[3:0]}`). It exhaustively sweeps all 2048 func/a/b combinations, compares each response against an internal reference model, and reports pass/fail, the error count and the first failing vector.

## Interface
- `SETTLE`, default 2: cycles each vector is held on `sw_out` before sampling `ledr_in`; legal range 1..15.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle pulse. Begins a sweep from IDLE or DONE; ignored while busy.
- `sw_out` output 16: registered switch word to the ALU under test.
- `ledr_in` input 16: LED word returned by the ALU under test.
- `busy` output 1: high from the cycle after an accepted `start` until the sweep ends.
- `done` output 1: high in DONE; held until the next accepted `start`.
- `pass` output 1: valid when `done`=1; 1 iff `err_count`=0.
- `err_count` output 16: number of mismatching vectors in the current or last sweep.
- `first_fail` output 16: `sw_out` value of the first mismatching vector; 0 if none.
- `first_ledr` output 16: `ledr_in` captured at the first mismatch; 0 if none.

## Operation
- **Vector index:** 11-bit `idx` = {func, b, a}. `a` is the innermost field, `func` the outermost. `sw_out` = {5'b0, idx}.
- **States:** IDLE, DRIVE, CHECK, DONE.
  - IDLE/DONE + `start`: go to DRIVE. Clear `idx`, `err_count`, `first_fail`, `first_ledr`, `pass`, `done`. Load `sw_out` = 0.
  - DRIVE: the settle counter counts up from 1. At `SETTLE`, go to CHECK.
  - CHECK: compare `ledr_in`, update the error registers, then:
    - if `idx`=2047, go to DONE;
    - otherwise increment `idx`, load the new `sw_out`, and go to DRIVE.
  - DONE: `busy`=0, `done`=1, `pass`=(`err_count`==0). `sw_out` holds the last vector.
- **Reference model.** All bits not listed below are masked. `ledr_in[15:10]` must always be 0.
  - func 000: expect `sum`=(a+b)[3:0], `cout`=carry-out of a+b, `overflow`=signed-add overflow, `f`=0.
  - func 001: expect `sum`=(a+~b+1)[3:0], `cout`=carry-out of a+~b+1 (1 when a>=b unsigned), `overflow`=signed-subtract overflow, `f`=0.
  - func 010: expect `f`=~a.
  - func 011: expect `f`=a&b.
  - func 100: expect `f`=a|b.
  - func 101: expect `f`=a^b.
  - For func 010–101, `sum`, `cout` and `overflow` are masked.
  - func 110: expect `f[0]`=(signed a < signed b).
  - func 111: expect `f[0]`=(a==b).
  - For func 110–111, `f[3:1]`, `sum`, `cout` and `overflow` are masked.
- **Mismatch handling:**
  - `err_count` increments and saturates at 16'hFFFF.
  - If `err_count` was 0 before this mismatch, capture `first_fail`=`sw_out` and `first_ledr`=`ledr_in`.

## Timing
- **Reset values:** `sw_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail`=0, `first_ledr`=0. FSM goes to IDLE.
- **`rst` mid-sweep:** aborts immediately to reset values; no partial results are retained.
- **Start latency:** `start` sampled at edge N gives `busy`=1 and `sw_out`=0 after edge N.
- **Per-vector timing:** each vector occupies exactly `SETTLE`+1 cycles (`SETTLE` DRIVE + 1 CHECK). `ledr_in` is sampled in CHECK, i.e. `SETTLE` full cycles after `sw_out` changed.
- **Sweep length:** the full sweep takes 2048×(`SETTLE`+1) cycles from the first DRIVE cycle. `done` rises the cycle after the final CHECK.
- **Start during busy:** `start` while `busy`=1 is ignored and produces no state change.
- **Start in DONE:** restarts the sweep. `done` falls and `busy` rises on the same edge.
- **Index handling:** `idx` never wraps within a sweep; 2047 is terminal.

## Test plan
- **Golden model, `SETTLE`=2:**
  - Stimulus: golden ALU model on `ledr_in`, one `start` pulse.
  - Required: `busy`=1 for 6144 cycles, then `done`=1, `pass`=1, `err_count`=0, `first_fail`=0.
- **`cout` stuck at 0:**
  - Stimulus: `cout` forced to 0.
  - Required: `err_count`=256 (120 add carries + 136 subtract a>=b), `first_fail`=16'h001F, `first_ledr[4]`=0, `pass`=0.
- **`ledr_in[15]` stuck at 1:**
  - Required: `err_count`=2048, `first_fail`=16'h0000.
- **`f[0]` inverted for func 111 only:**
  - Required: `err_count`=256, `first_fail`=16'h0700.
- **Reset mid-sweep:**
  - Stimulus: assert `rst` at vector 500 with errors already logged.
  - Required: all outputs at reset values on the next edge. A subsequent `start` runs a clean full sweep.
- **Start handling:**
  - Stimulus: pulse `start` during `busy`, then again in DONE.
  - Required: the first pulse has no effect on timing or counts. The second restarts with `err_count` cleared, `done` low and `busy` high on the same edge.

Source files
------------

// File: rtl/alu_sweep_checker_if.sv
// Board-side bus between the sweep checker and the 4-bit ALU under test.
// The switch word goes out to the ALU and the LED word comes back.
interface alu_sweep_checker_if;
    logic [15:0] sw_out;
    logic [15:0] ledr_in;

    modport master (output sw_out, input  ledr_in);
    modport slave  (input  sw_out, output ledr_in);
endinterface

// File: rtl/alu_sweep_checker.sv
// Exhaustive func/a/b sweep of the 4-bit switch ALU with an internal reference model.
// Reports the error count and the first failing vector and LED word.
module alu_sweep_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    alu_sweep_checker_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [15:0]          first_fail,
    output logic [15:0]          first_ledr
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t      state, state_nxt;
    logic [10:0] idx;
    logic [3:0]  cnt;

    logic [3:0]  a, b;
    logic [2:0]  func;
    logic [4:0]  add5, sub5;
    logic        ov_add, ov_sub;
    logic [15:0] exp_word, mask;
    logic        mismatch;

    assign a    = idx[3:0];
    assign b    = idx[7:4];
    assign func = idx[10:8];

    assign bus.sw_out = {5'b0, idx};
    assign busy       = (state == DRIVE) || (state == CHECK);
    assign done       = (state == DONE);
    assign pass       = done && (err_count == '0);

    // Reference LED word plus the mask of bits that matter for this func.
    always_comb begin
        add5     = {1'b0, a} + {1'b0, b};
        sub5     = {1'b0, a} + {1'b0, ~b} + 5'd1;
        ov_add   = (a[3] == b[3]) && (add5[3] != a[3]);
        ov_sub   = (a[3] != b[3]) && (sub5[3] != a[3]);
        exp_word = '0;
        mask     = '1;
        case (func)
            3'd0: exp_word[5:0] = {ov_add, add5[4], add5[3:0]};
            3'd1: exp_word[5:0] = {ov_sub, sub5[4], sub5[3:0]};
            3'd2: begin exp_word[9:6] = ~a;    mask = 16'hFFC0; end
            3'd3: begin exp_word[9:6] = a & b; mask = 16'hFFC0; end
            3'd4: begin exp_word[9:6] = a | b; mask = 16'hFFC0; end
            3'd5: begin exp_word[9:6] = a ^ b; mask = 16'hFFC0; end
            3'd6: begin exp_word[6] = $signed(a) < $signed(b); mask = 16'hFC40; end
            default: begin exp_word[6] = (a == b); mask = 16'hFC40; end
        endcase
        mismatch = ((bus.ledr_in ^ exp_word) & mask) != '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = DRIVE;
            DRIVE:      if (cnt == SETTLE_CNT) state_nxt = CHECK;
            CHECK:      state_nxt = (idx == 11'd2047) ? DONE : DRIVE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            cnt        <= '0;
            err_count  <= '0;
            first_fail <= '0;
            first_ledr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx        <= '0;
                        cnt        <= 4'd1;
                        err_count  <= '0;
                        first_fail <= '0;
                        first_ledr <= '0;
                    end
                end
                DRIVE: begin
                    if (cnt != SETTLE_CNT) cnt <= cnt + 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        if (err_count == '0) begin
                            first_fail <= bus.sw_out;
                            first_ledr <= bus.ledr_in;
                        end
                    end
                    if (idx != 11'd2047) begin
                        idx <= idx + 11'd1;
                        cnt <= 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
